// File: rtl/dispense_sequencer.sv
// dispense_sequencer
//   Drives the drink valves for one paid order: base drink (coffee or
//   chocolate), then optional extra milk, then optional extra sugar, each
//   valve open for a programmed number of qualified cycles. A qualified
//   cycle is one with tank_ok=1 and abort=0. The sequence stalls while the
//   water tank is not ready, can be aborted, and counts completed cups.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    order request, accepted only in IDLE
//   drink    0 = coffee, 1 = chocolate (sampled with accepted start)
//   x_milk   extra milk flag (sampled with accepted start)
//   x_sugar  extra sugar flag (sampled with accepted start)
//   tank_ok  water/pressure ready; 0 stalls the sequence
//   abort    cancel the order in progress
//   busy     state is not IDLE
//   cafea_v, cioco_v, lapte_v, zahar_v  valve drives
//   phase    0 IDLE, 1 BASE, 2 MILK, 3 SUGAR, 4 DONE
//   done     high for the single DONE cycle
//   aborted  one-cycle pulse after an abort is taken
//   cups     saturating count of completed cups
module dispense_sequencer #(
  parameter int unsigned T_BASE  = 8,
  parameter int unsigned T_MILK  = 4,
  parameter int unsigned T_SUGAR = 2,
  parameter int unsigned CW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       drink,
  input  logic       x_milk,
  input  logic       x_sugar,
  input  logic       tank_ok,
  input  logic       abort,
  output logic       busy,
  output logic       cafea_v,
  output logic       cioco_v,
  output logic       lapte_v,
  output logic       zahar_v,
  output logic [2:0] phase,
  output logic       done,
  output logic       aborted,
  output logic [7:0] cups
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BASE  = 3'd1,
    S_MILK  = 3'd2,
    S_SUGAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] timer, timer_n;
  logic          drink_q, milk_q, sugar_q;
  logic          take_abort;
  logic          qual;
  logic          last;

  assign qual = tank_ok & ~abort;
  assign last = (timer == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      drink_q <= 1'b0;
      milk_q  <= 1'b0;
      sugar_q <= 1'b0;
      aborted <= 1'b0;
      cups    <= '0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      aborted <= take_abort;
      if (state == S_IDLE && start) begin
        drink_q <= drink;
        milk_q  <= x_milk;
        sugar_q <= x_sugar;
      end
      if (state == S_DONE && cups != '1)
        cups <= cups + 8'd1;
    end
  end

  // The timer holds the remaining qualified cycles of the current phase;
  // expiry is the qualified cycle in which it reads 1. Abort is checked
  // before expiry so it always wins.
  always_comb begin
    state_n    = state;
    timer_n    = timer;
    take_abort = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_BASE;
          timer_n = CW'(T_BASE);
        end
      end
      S_BASE, S_MILK, S_SUGAR: begin
        if (abort) begin
          state_n    = S_IDLE;
          timer_n    = '0;
          take_abort = 1'b1;
        end else if (qual) begin
          if (!last) begin
            timer_n = timer - CW'(1);
          end else if (state == S_BASE && milk_q) begin
            state_n = S_MILK;
            timer_n = CW'(T_MILK);
          end else if (state != S_SUGAR && sugar_q) begin
            state_n = S_SUGAR;
            timer_n = CW'(T_SUGAR);
          end else begin
            state_n = S_DONE;
            timer_n = '0;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign phase   = state;
  assign cafea_v = (state == S_BASE) & ~drink_q & tank_ok;
  assign cioco_v = (state == S_BASE) &  drink_q & tank_ok;
  assign lapte_v = (state == S_MILK)  & tank_ok;
  assign zahar_v = (state == S_SUGAR) & tank_ok;

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
Sequences the drink-dispensing valves once the selection FSM has resolved a paid order. It latches the recipe: base drink (coffee or chocolate) plus the extra-milk and extra-sugar flags. It then drives the cafea, cioco, lapte and zahar valves one after another, each for a programmed number of cycles. It stalls while the water tank is not ready, supports abort, and keeps a saturating count of completed cups.

Parameters:
T_BASE, 8, cycles the base valve (cafea or cioco) stays open; must be >= 1
T_MILK, 4, cycles lapte stays open when extra milk is selected; must be >= 1
T_SUGAR, 2, cycles zahar stays open when extra sugar is selected; must be >= 1
CW, 4, width of the phase timer; must satisfy 2^CW > max(T_BASE, T_MILK, T_SUGAR)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  order request; accepted only in IDLE
drink  in  1  0 = coffee, 1 = chocolate; sampled with an accepted start
x_milk  in  1  extra milk; sampled with an accepted start
x_sugar  in  1  extra sugar; sampled with an accepted start
tank_ok  in  1  1 = water and pressure ready; 0 stalls the sequence
abort  in  1  cancel the current order
busy  out  1  1 whenever the state is not IDLE
cafea_v  out  1  coffee valve
cioco_v  out  1  chocolate valve
lapte_v  out  1  milk valve
zahar_v  out  1  sugar valve
phase  out  3  0 IDLE, 1 BASE, 2 MILK, 3 SUGAR, 4 DONE
done  out  1  1 for the single DONE cycle
aborted  out  1  one-cycle registered pulse after an abort is taken
cups  out  8  completed-cup counter, saturating

Behaviour:
- Reset: the following are forced in the cycle after rst is sampled high, regardless of current state, including mid-dispense:
  - state IDLE
  - all valves, busy, done and aborted = 0
  - phase = 0, cups = 0
  - latched recipe and timer cleared
- Clocking: all state changes happen on the rising edge of clk.
- IDLE:
  - start = 1 latches drink, x_milk and x_sugar.
  - The next state is BASE, with the timer loaded for T_BASE.
- Timer rule: a phase lasts exactly T qualified cycles. A qualified cycle is one with tank_ok = 1 and abort = 0. The timer does not advance in other cycles.
- BASE: on expiry go to MILK if x_milk is latched, else SUGAR if x_sugar is latched, else DONE.
- MILK: on expiry go to SUGAR if x_sugar is latched, else DONE.
- SUGAR: on expiry go to DONE.
- DONE:
  - Lasts one cycle with done = 1.
  - cups increments by 1 on exit, holding at 255.
  - The next state is IDLE.
- Valve outputs are a combinational decode of state, latched recipe and tank_ok:
  - cafea_v = BASE & ~drink & tank_ok
  - cioco_v = BASE & drink & tank_ok
  - lapte_v = MILK & tank_ok
  - zahar_v = SUGAR & tank_ok
  - At most one valve is ever high.
- Stall: with tank_ok = 0 the state and timer hold and all valves are low. The sequence resumes when tank_ok returns to 1.
- Abort:
  - Sampled high in BASE, MILK or SUGAR: the next state is IDLE and aborted = 1 for that one cycle. cups is unchanged.
  - Abort beats timer expiry in the same cycle.
  - Abort in IDLE or DONE has no effect; DONE completes and counts.
- start while busy, including the DONE cycle, is ignored. Recipe inputs are don't-care outside an accepted start.
- Latency, measured from the edge on which start is sampled with no stalls: the first valve rises 1 cycle later, and done rises 1 + T_BASE + (x_milk ? T_MILK : 0) + (x_sugar ? T_SUGAR : 0) cycles later.

Test Plan:
- Reset, then start with drink=0 and no extras at cycle 0 → cafea_v=1 in cycles 1–8, done=1 in cycle 9, busy=1 in cycles 1–9, cups=1 in cycle 10, all other valves 0.
- start with drink=1, x_milk=1, x_sugar=1 → cioco_v in cycles 1–8, lapte_v in 9–12, zahar_v in 13–14, done in 15; phase reads 1,2,3,4, then 0.
- Coffee order with tank_ok=0 during cycles 3–5 → cafea_v low in 3–5, valve open 8 cycles in total, done in cycle 12.
- Milk order with abort=1 in cycle 10 → phase=0 and aborted=1 in cycle 11, lapte_v=0 from cycle 11, done never asserted, cups unchanged; a new start in cycle 12 is accepted.
- start pulsed in cycles 4 and 9 of an active coffee order → ignored: one done, cups increments by exactly 1.
- rst=1 in cycle 5 of an order → next cycle all outputs 0 and phase=0. With T_BASE=T_MILK=T_SUGAR=1 run 260 orders → cups saturates at 255.
